// File: rtl/lisa_qqspi_engine_if.sv
// rtl/lisa_qqspi_engine_if.sv - request/response bus between the QSPI arbiter and the QSPI engine
interface lisa_qqspi_engine_if #(
    parameter int CHIP_SELECTS = 2
);
    logic [23:0]             addr;
    logic [15:0]             wdata;
    logic [1:0]              wstrb;
    logic                    valid;
    logic [3:0]              xfer_len;
    logic [CHIP_SELECTS-1:0] ce_ctrl;
    logic                    custom_spi_cmd;
    logic [7:0]              cmd_quad_write;
    logic [15:0]             rdata;
    logic                    ready;
    logic                    xfer_done;

    modport master (
        output addr, wdata, wstrb, valid, xfer_len, ce_ctrl, custom_spi_cmd, cmd_quad_write,
        input  rdata, ready, xfer_done
    );

    modport slave (
        input  addr, wdata, wstrb, valid, xfer_len, ce_ctrl, custom_spi_cmd, cmd_quad_write,
        output rdata, ready, xfer_done
    );
endinterface

// File: rtl/lisa_qqspi_engine.sv
// rtl/lisa_qqspi_engine.sv - QSPI burst engine (SCK = clk/2); LISA_QQSPI_SIO_SYNC_EN adds an sio_in register stage
module lisa_qqspi_engine #(
    parameter int         CHIP_SELECTS   = 2,
    parameter int         DUMMY_CYCLES   = 6,
    parameter logic [7:0] CMD_QUAD_READ  = 8'hEB,
    parameter logic [7:0] CMD_QUAD_WRITE = 8'h38
) (
    input  logic                    clk,
    input  logic                    rst,
    lisa_qqspi_engine_if.slave      bus,
    output logic                    sck,
    output logic [CHIP_SELECTS-1:0] ce_n,
    output logic [3:0]              sio_out,
    output logic [3:0]              sio_oe,
    input  logic [3:0]              sio_in
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

    state_t                  state;
    logic                    hi;
    logic [7:0]              rem;
    logic [4:0]              words_left;
    logic                    is_rd;
    logic [1:0]              strb_lat;
    logic [CHIP_SELECTS-1:0] ce_lat;
    logic [7:0]              cmd_sr;
    logic [23:0]             addr_sr;
    logic [15:0]             data_sr;
    logic [11:0]             rx_sr;
    logic                    wr_pend;

    // Wire order of a word: low byte first, high nibble first; a high-byte-only write sends just wdata[15:8].
    function automatic logic [15:0] wire_order(input logic [15:0] w, input logic [1:0] s);
        return (s == 2'b10) ? {w[15:8], 8'h00} : {w[7:0], w[15:8]};
    endfunction

    logic [7:0]  nib_last;
    logic [15:0] tx_word;
    assign nib_last = (strb_lat == 2'b01 || strb_lat == 2'b10) ? 8'd1 : 8'd3;
    // The first word was captured at accept; later words are taken live from the bus.
    assign tx_word  = (state == DATA) ? wire_order(bus.wdata, strb_lat) : data_sr;

    logic       samp, samp_last;
    logic       rx_en, rx_last;
    logic [3:0] rx_nib;
    assign samp      = (state == DATA) && hi && is_rd;
    assign samp_last = samp && (rem == 8'd0);

`ifdef LISA_QQSPI_SIO_SYNC_EN
    logic [3:0] sio_q;
    logic       samp_q, samp_last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sio_q       <= 4'h0;
            samp_q      <= 1'b0;
            samp_last_q <= 1'b0;
        end else begin
            sio_q       <= sio_in;
            samp_q      <= samp;
            samp_last_q <= samp_last;
        end
    end
    assign rx_en   = samp_q;
    assign rx_last = samp_last_q;
    assign rx_nib  = sio_q;
`else
    assign rx_en   = samp;
    assign rx_last = samp_last;
    assign rx_nib  = sio_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hi         <= 1'b0;
            rem        <= 8'd0;
            words_left <= 5'd0;
            is_rd      <= 1'b0;
            strb_lat   <= 2'b00;
            ce_lat     <= '0;
            cmd_sr     <= 8'h00;
            addr_sr    <= 24'h0;
            data_sr    <= 16'h0;
            rx_sr      <= 12'h0;
            wr_pend    <= 1'b0;
            sck        <= 1'b0;
            ce_n       <= '1;
            sio_out    <= 4'h0;
            sio_oe     <= 4'h0;
            bus.rdata     <= 16'h0;
            bus.ready     <= 1'b0;
            bus.xfer_done <= 1'b0;
        end else begin
            bus.ready     <= wr_pend;
            bus.xfer_done <= 1'b0;
            wr_pend       <= 1'b0;

            if (rx_en) begin
                rx_sr <= {rx_sr[7:0], rx_nib};
                if (rx_last) begin
                    bus.rdata <= {rx_sr[3:0], rx_nib, rx_sr[11:8], rx_sr[7:4]};
                    bus.ready <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        // hi=1 makes the next edge behave like the end of an SCK period, so CE drops one clk after accept.
                        state      <= CMD;
                        hi         <= 1'b1;
                        rem        <= 8'd8;
                        is_rd      <= (bus.wstrb == 2'b00);
                        strb_lat   <= bus.wstrb;
                        ce_lat     <= bus.ce_ctrl;
                        cmd_sr     <= (bus.wstrb == 2'b00) ? CMD_QUAD_READ :
                                      (bus.custom_spi_cmd ? bus.cmd_quad_write : CMD_QUAD_WRITE);
                        addr_sr    <= (bus.wstrb == 2'b10) ? bus.addr + 24'd1 : bus.addr;
                        data_sr    <= wire_order(bus.wdata, bus.wstrb);
                        words_left <= (bus.xfer_len == 4'd0) ? 5'd16 : {1'b0, bus.xfer_len};
                        wr_pend    <= (bus.wstrb != 2'b00);
                    end
                end
                DONE: begin
                    bus.xfer_done <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    if (!hi) begin
                        sck <= 1'b1;
                        hi  <= 1'b1;
                    end else begin
                        sck <= 1'b0;
                        hi  <= 1'b0;
                        if (rem != 8'd0) begin
                            rem <= rem - 8'd1;
                            case (state)
                                CMD: begin
                                    ce_n    <= ~ce_lat;
                                    sio_oe  <= 4'b0001;
                                    sio_out <= {3'b000, cmd_sr[7]};
                                    cmd_sr  <= cmd_sr << 1;
                                end
                                ADDR: begin
                                    sio_out <= addr_sr[23:20];
                                    addr_sr <= addr_sr << 4;
                                end
                                DATA: begin
                                    sio_out <= is_rd ? 4'h0 : data_sr[15:12];
                                    data_sr <= data_sr << 4;
                                end
                                default: ;
                            endcase
                        end else begin
                            case (state)
                                CMD: begin
                                    state   <= ADDR;
                                    rem     <= 8'd5;
                                    sio_oe  <= 4'hF;
                                    sio_out <= addr_sr[23:20];
                                    addr_sr <= addr_sr << 4;
                                end
                                ADDR, DUMMY: begin
                                    if (state == ADDR && is_rd) begin
                                        state   <= DUMMY;
                                        rem     <= 8'(DUMMY_CYCLES - 1);
                                        sio_oe  <= 4'h0;
                                        sio_out <= 4'h0;
                                    end else begin
                                        state   <= DATA;
                                        rem     <= nib_last;
                                        sio_oe  <= is_rd ? 4'h0 : 4'hF;
                                        sio_out <= is_rd ? 4'h0 : tx_word[15:12];
                                        data_sr <= tx_word << 4;
                                    end
                                end
                                default: begin
                                    if (words_left == 5'd1) begin
                                        state   <= DONE;
                                        ce_n    <= '1;
                                        sio_oe  <= 4'h0;
                                        sio_out <= 4'h0;
                                    end else begin
                                        words_left <= words_left - 5'd1;
                                        rem        <= nib_last;
                                        sio_out    <= is_rd ? 4'h0 : tx_word[15:12];
                                        data_sr    <= tx_word << 4;
                                        wr_pend    <= ~is_rd;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lisa_qqspi_engine.sv
// tb/tb_lisa_qqspi_engine.sv - randomized self-checking bench for lisa_qqspi_engine against a cycle-timeline model
module tb_lisa_qqspi_engine;
    localparam int CS    = 2;
    localparam int DUMMY = 6;
`ifdef LISA_QQSPI_SIO_SYNC_EN
    localparam int RS = 1;
`else
    localparam int RS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sck;
    logic [CS-1:0] ce_n;
    logic [3:0]    sio_out, sio_oe, sio_in;

    lisa_qqspi_engine_if #(.CHIP_SELECTS(CS)) bus ();

    lisa_qqspi_engine #(.CHIP_SELECTS(CS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sck     (sck),
        .ce_n    (ce_n),
        .sio_out (sio_out),
        .sio_oe  (sio_oe),
        .sio_in  (sio_in)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [15:0] words [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Nibble j of a word on the wire: d[7:4], d[3:0], d[15:12], d[11:8]; high-byte-only starts at d[15:12].
    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] s, input int j);
        logic [3:0] n [4];
        n[0] = w[7:4];
        n[1] = w[3:0];
        n[2] = w[15:12];
        n[3] = w[11:8];
        return (s == 2'b10) ? n[(j + 2) % 4] : n[j % 4];
    endfunction

    task automatic xfer(input logic [23:0] a, input int len_in, input logic [1:0] s,
                        input logic [CS-1:0] ce, input logic cust, input logic [7:0] cw);
        int          nw, npw, d0, de, idx, rk;
        bit          rd;
        logic [7:0]  op;
        logic [23:0] ae;
        logic        e_sck, e_rdy;
        logic [CS-1:0] e_ce;
        logic [3:0]  e_oe;
        nw  = (len_in == 0) ? 16 : len_in;
        rd  = (s == 2'b00);
        npw = (s == 2'b01 || s == 2'b10) ? 2 : 4;
        op  = rd ? 8'hEB : (cust ? cw : 8'h38);
        ae  = (s == 2'b10) ? a + 24'd1 : a;
        d0  = rd ? 29 + 2 * DUMMY : 29;
        de  = d0 + 2 * npw * nw - 1;

        bus.addr = a; bus.xfer_len = len_in[3:0]; bus.wstrb = s; bus.ce_ctrl = ce;
        bus.custom_spi_cmd = cust; bus.cmd_quad_write = cw; bus.wdata = words[0]; bus.valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Request fields must be held internally; scramble them once accepted.
        bus.valid = 1'b0; bus.addr = 24'($urandom); bus.xfer_len = 4'($urandom);
        bus.wstrb = 2'($urandom); bus.ce_ctrl = CS'($urandom); bus.custom_spi_cmd = 1'($urandom);
        bus.cmd_quad_write = 8'($urandom);
        check("accept_gap", 32'({sck, ce_n}), 32'({1'b0, {CS{1'b1}}}));

        for (int c = 1; c <= de + 2; c++) begin
            @(negedge clk);
            e_sck = (c <= de) && (c % 2 == 0);
            e_ce  = (c <= de) ? ~ce : {CS{1'b1}};
            if (c <= 16)      e_oe = 4'b0001;
            else if (c <= 28) e_oe = 4'hF;
            else if (c < d0)  e_oe = 4'h0;
            else if (c <= de) e_oe = rd ? 4'h0 : 4'hF;
            else              e_oe = 4'h0;
            check($sformatf("pins_c%0d", c), 32'({sck, ce_n, sio_oe}), 32'({e_sck, e_ce, e_oe}));

            if (c <= 16)
                check($sformatf("cmd_c%0d", c), 32'(sio_out), 32'({3'b000, op[7 - (c - 1) / 2]}));
            else if (c <= 28)
                check($sformatf("addr_c%0d", c), 32'(sio_out), 32'(ae[23 - 4 * ((c - 17) / 2) -: 4]));
            else if (!rd && c >= d0 && c <= de) begin
                idx = (c - d0) / 2;
                check($sformatf("wdat_c%0d", c), 32'(sio_out), 32'(nib(words[idx / npw], s, idx % npw)));
            end

            e_rdy = 1'b0;
            rk    = -1;
            for (int k = 0; k < nw; k++) begin
                if (rd && c == d0 + 8 * (k + 1) + RS) begin e_rdy = 1'b1; rk = k; end
                if (!rd && ((k == 0 && c == 1) || (k > 0 && c == d0 + 2 * npw * k + 1))) begin
                    e_rdy = 1'b1; rk = k;
                end
            end
            check($sformatf("ready_c%0d", c), 32'(bus.ready), 32'(e_rdy));
            check($sformatf("done_c%0d", c), 32'(bus.xfer_done), 32'(c == de + 2));
            if (rd && e_rdy)
                check($sformatf("rdata_w%0d", rk), 32'(bus.rdata), 32'(words[rk]));

            if (!rd && e_rdy)
                bus.wdata = (rk + 1 < nw) ? words[rk + 1] : 16'($urandom);
            if (rd && c >= d0 && c <= de) begin
                idx    = (c - d0) / 2;
                sio_in = nib(words[idx / 4], 2'b00, idx % 4);
            end else begin
                sio_in = 4'($urandom);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] s;
        int         len;
        rst = 1'b1;
        bus.valid = 1'b0; bus.addr = 24'h0; bus.wdata = 16'h0; bus.wstrb = 2'b00; bus.xfer_len = 4'd1;
        bus.ce_ctrl = 2'b01; bus.custom_spi_cmd = 1'b0; bus.cmd_quad_write = 8'h00; sio_in = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_pins", 32'({sck, ce_n, sio_oe, sio_out}), 32'({1'b0, {CS{1'b1}}, 4'h0, 4'h0}));
        check("rst_resp", 32'({bus.rdata, bus.ready, bus.xfer_done}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        words[0] = 16'h1234;
        xfer(24'h000100, 1, 2'b00, 2'b01, 1'b0, 8'h00);

        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        xfer(24'($urandom), 3, 2'b00, 2'b10, 1'b0, 8'h00);

        words[0] = 16'hBEEF; words[1] = 16'hCAFE;
        xfer(24'h002000, 2, 2'b11, 2'b01, 1'b0, 8'h55);

        words[0] = 16'h9A5C;
        xfer(24'h000010, 1, 2'b10, 2'b01, 1'b1, 8'h02);

        words[0] = 16'h3C7E;
        xfer(24'h0000F0, 1, 2'b01, 2'b10, 1'b0, 8'h02);

        for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
        xfer(24'hABCDEF, 0, 2'b00, 2'b01, 1'b0, 8'h00);

        // Reset in the middle of the address phase.
        bus.addr = 24'h123456; bus.wstrb = 2'b00; bus.xfer_len = 4'd2; bus.ce_ctrl = 2'b01; bus.valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_in_burst", 32'(ce_n), 32'(2'b10));
        rst = 1'b1;
        #1;
        check("rst_mid_pins", 32'({sck, ce_n, sio_oe, sio_out}), 32'({1'b0, {CS{1'b1}}, 4'h0, 4'h0}));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_mid_resp", 32'({bus.ready, bus.xfer_done}), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({bus.ready, bus.xfer_done, ce_n}), 32'({2'b00, {CS{1'b1}}}));
        end
        words[0] = 16'h5A5A; words[1] = 16'hC3C3;
        xfer(24'h000200, 2, 2'b00, 2'b10, 1'b0, 8'h00);

        for (int t = 0; t < 10; t++) begin
            s   = 2'($urandom_range(0, 3));
            len = (s == 2'b01 || s == 2'b10) ? 1 : $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
            xfer(24'($urandom), len, s, CS'(1 << $urandom_range(0, CS - 1)), 1'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
